// File: rtl/des_key_rotator.sv
// DES key-schedule front end: PC-1 on the loaded key, then 16 rotated C/D beats
// over a valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_rotator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    output logic        ready,
    output logic        cd_valid,
    input  logic        cd_ready,
    output logic [55:0] cd_out,
    output logic [3:0]  round,
    output logic        done
);

    // Bit numbering: FIPS key bit i is key_in[64-i] (bit 1 = MSB of the printed key).
    // FIPS C bit i lives at c_reg[i-1], D bit i at d_reg[i-1]; cd_out = {D, C}.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int PC1_C [0:27] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36};
    localparam int PC1_D [0:27] = '{63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    // Bit k set when the schedule shifts by 2 at iteration k (k = 1..16).
    localparam logic [31:0] SHIFT_IS_2 = 32'h0000_FDF8;

    state_t      state_reg, state_next;
    logic        load, advance, last;
    logic [27:0] pc1_c, pc1_d;
    logic [27:0] c_reg, d_reg, c_rot, d_rot;
    logic [3:0]  round_reg;
    logic        cd_valid_reg, done_reg, decrypt_reg;
    logic [4:0]  shift_idx;
    logic        shift_none, shift_two;

    genvar gi;
    generate
        for (gi = 0; gi < 28; gi++) begin : g_pc1
            assign pc1_c[gi] = key_in[64 - PC1_C[gi]];
            assign pc1_d[gi] = key_in[64 - PC1_D[gi]];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        advance    = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (cd_ready) begin
                    advance = 1'b1;
                    if (round_reg == 4'd15) begin
                        last       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decrypt walks the schedule backwards, so each step undoes the next-lower shift.
    // After the last decrypt beat one more right shift restores CD0.
    always_comb begin
        shift_idx  = decrypt_reg ? (5'd16 - {1'b0, round_reg}) : ({1'b0, round_reg} + 5'd2);
        shift_none = !decrypt_reg && (round_reg == 4'd15);
        shift_two  = SHIFT_IS_2[shift_idx];
        c_rot      = c_reg;
        d_rot      = d_reg;
        if (!shift_none) begin
            if (decrypt_reg) begin
                c_rot = shift_two ? {c_reg[25:0], c_reg[27:26]} : {c_reg[26:0], c_reg[27]};
                d_rot = shift_two ? {d_reg[25:0], d_reg[27:26]} : {d_reg[26:0], d_reg[27]};
            end else begin
                c_rot = shift_two ? {c_reg[1:0], c_reg[27:2]} : {c_reg[0], c_reg[27:1]};
                d_rot = shift_two ? {d_reg[1:0], d_reg[27:2]} : {d_reg[0], d_reg[27:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            c_reg        <= '0;
            d_reg        <= '0;
            round_reg    <= '0;
            cd_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            decrypt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= last;
            if (load) begin
                decrypt_reg  <= decrypt;
                round_reg    <= '0;
                cd_valid_reg <= 1'b1;
                c_reg        <= decrypt ? pc1_c : {pc1_c[0], pc1_c[27:1]};
                d_reg        <= decrypt ? pc1_d : {pc1_d[0], pc1_d[27:1]};
            end else if (advance) begin
                c_reg <= c_rot;
                d_reg <= d_rot;
                if (last) begin
                    cd_valid_reg <= 1'b0;
                    round_reg    <= '0;
                end else begin
                    round_reg <= round_reg + 4'd1;
                end
            end
        end
    end

    assign ready    = (state_reg == IDLE);
    assign cd_valid = cd_valid_reg;
    assign cd_out   = {d_reg, c_reg};
    assign round    = round_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_des_key_rotator.sv
// Testbench for des_key_rotator: FIPS schedule model feeding a beat scoreboard,
// plus known-answer, stall, restart and mid-run reset scenarios.
module tb_des_key_rotator;

    logic        clk = 1'b0;
    logic        rst_n, start, decrypt, cd_ready;
    logic [63:0] key_in;
    logic        ready, cd_valid, done;
    logic [55:0] cd_out;
    logic [3:0]  round;

    int checks = 0;
    int errors = 0;

    logic [55:0] exp_cd_q [$];
    logic [3:0]  exp_rnd_q [$];
    logic [55:0] mon_cd;
    logic [3:0]  mon_rnd;

    localparam logic [63:0] FIPS_KEY = 64'h1334_5779_9BBC_DFF1;
    localparam int PC1_T [0:55] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [0:47] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_rotator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .decrypt  (decrypt),
        .key_in   (key_in),
        .ready    (ready),
        .cd_valid (cd_valid),
        .cd_ready (cd_ready),
        .cd_out   (cd_out),
        .round    (round),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Model values are kept in printed form: bit 1 is the MSB of each 28-bit half.
    function automatic logic [27:0] rotl_p(input logic [27:0] x, input int n);
        logic [27:0] r = x;
        for (int i = 0; i < n; i++) r = {r[26:0], r[27]};
        return r;
    endfunction

    function automatic logic [55:0] to_cd(input logic [27:0] cp, input logic [27:0] dp);
        logic [55:0] r;
        for (int i = 1; i <= 28; i++) begin
            r[i-1]  = cp[28-i];
            r[27+i] = dp[28-i];
        end
        return r;
    endfunction

    function automatic logic [27:0] c_print(input logic [55:0] cd);
        logic [27:0] p;
        for (int i = 1; i <= 28; i++) p[28-i] = cd[i-1];
        return p;
    endfunction

    function automatic logic [27:0] d_print(input logic [55:0] cd);
        logic [27:0] p;
        for (int i = 1; i <= 28; i++) p[28-i] = cd[27+i];
        return p;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        for (int j = 1; j <= 48; j++) k[48-j] = cd[PC2_T[j-1]-1];
        return k;
    endfunction

    task automatic push_expected(input logic [63:0] key, input logic dec);
        logic [27:0] cp, dp;
        logic [55:0] sched [16];
        for (int j = 1; j <= 28; j++) begin
            cp[28-j] = key[64-PC1_T[j-1]];
            dp[28-j] = key[64-PC1_T[27+j]];
        end
        for (int k = 0; k < 16; k++) begin
            cp = rotl_p(cp, SHIFTS[k]);
            dp = rotl_p(dp, SHIFTS[k]);
            sched[k] = to_cd(cp, dp);
        end
        for (int n = 0; n < 16; n++) begin
            exp_cd_q.push_back(dec ? sched[15-n] : sched[n]);
            exp_rnd_q.push_back(4'(n));
        end
    endtask

    // Called #1 after a posedge while ready=1; returns #1 after the accepting edge
    // with key_in/decrypt scrambled so later changes are shown to have no effect.
    task automatic do_start(input logic [63:0] key, input logic dec);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        push_expected(key, dec);
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = {$urandom(), $urandom()};
        decrypt = ~dec;
    endtask

    task automatic drive_until_done(output bit got, output logic [55:0] b0, output logic [55:0] b15);
        got = 1'b0;
        b0  = '0;
        b15 = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            cd_ready = 1'b1;
            @(negedge clk);
            if (cd_valid && round == 4'd0)  b0  = cd_out;
            if (cd_valid && round == 4'd15) b15 = cd_out;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && cd_valid && cd_ready) begin
            checks++;
            if (exp_cd_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: beat cd_out=%h round=%0d, expected no beat", cd_out, round);
            end else begin
                mon_cd  = exp_cd_q.pop_front();
                mon_rnd = exp_rnd_q.pop_front();
                if (cd_out !== mon_cd || round !== mon_rnd)  begin
                    errors++;
                    $display("FAIL sb_beat: got cd_out=%h round=%0d, expected cd_out=%h round=%0d",
                             cd_out, round, mon_cd, mon_rnd);
                end else begin
                    $display("beat round=%0d cd_out=%h ok", round, cd_out);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; cd_ready = 1'b0; key_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready, cd_valid, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got ready/valid/done=%b%b%b, expected 100", ready, cd_valid, done);
        end
        checks++;
        if (round !== 4'd0 || cd_out !== 56'd0) begin
            errors++;
            $display("FAIL reset_data: got round=%0d cd_out=%h, expected 0/0", round, cd_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt_vector();
        logic [55:0] b0, b15;
        b0 = '0; b15 = '0;
        cd_ready = 1'b1;
        do_start(FIPS_KEY, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 16) begin
                if ({cd_valid, ready, done, round} !== {3'b100, 4'(k-1)}) begin
                    errors++;
                    $display("FAIL enc_timing cycle %0d: got valid/ready/done=%b%b%b round=%0d, expected 100 round=%0d",
                             k, cd_valid, ready, done, round, k-1);
                end
                if (k == 1)  b0  = cd_out;
                if (k == 16) b15 = cd_out;
            end else if (k == 17) begin
                if ({cd_valid, ready, done} !== 3'b011) begin
                    errors++;
                    $display("FAIL enc_done: got valid/ready/done=%b%b%b at T+17, expected 011", cd_valid, ready, done);
                end
            end else if (done !== 1'b0) begin
                errors++;
                $display("FAIL enc_done_width: got done=%b at T+18, expected 0", done);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (c_print(b0) !== 28'hE19955F || d_print(b0) !== 28'hAACCF1E) begin
            errors++;
            $display("FAIL enc_beat0: got C=%h D=%h, expected C=e19955f D=aaccf1e", c_print(b0), d_print(b0));
        end
        checks++;
        if (pc2(b0) !== 48'h1B02EFFC7072) begin
            errors++;
            $display("FAIL enc_k1: got %h, expected 1b02effc7072", pc2(b0));
        end
        checks++;
        if (c_print(b15) !== 28'hF0CCAAF || d_print(b15) !== 28'h556678F) begin
            errors++;
            $display("FAIL enc_beat15: got C=%h D=%h, expected C=f0ccaaf D=556678f", c_print(b15), d_print(b15));
        end
        checks++;
        if (pc2(b15) !== 48'hCB3D8B0E17F5) begin
            errors++;
            $display("FAIL enc_k16: got %h, expected cb3d8b0e17f5", pc2(b15));
        end
        $display("encrypt vector: K1=%h K16=%h", pc2(b0), pc2(b15));
    endtask

    task automatic test_decrypt_vector();
        bit got;
        logic [55:0] b0, b15;
        do_start(FIPS_KEY, 1'b1);
        drive_until_done(got, b0, b15);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL dec_timeout: got no done within budget, expected done");
        end
        checks++;
        if (c_print(b0) !== 28'hF0CCAAF || d_print(b0) !== 28'h556678F) begin
            errors++;
            $display("FAIL dec_beat0: got C=%h D=%h, expected C=f0ccaaf D=556678f", c_print(b0), d_print(b0));
        end
        checks++;
        if (pc2(b0) !== 48'hCB3D8B0E17F5 || pc2(b15) !== 48'h1B02EFFC7072) begin
            errors++;
            $display("FAIL dec_keys: got first=%h last=%h, expected cb3d8b0e17f5 / 1b02effc7072", pc2(b0), pc2(b15));
        end
        $display("decrypt vector: first=%h last=%h", pc2(b0), pc2(b15));
    endtask

    task automatic test_stalls(input logic dec);
        bit got, held;
        int stall7;
        logic [55:0] held_cd;
        logic [3:0]  held_rnd;
        got = 1'b0; held = 1'b0; stall7 = 0; held_cd = '0; held_rnd = '0;
        cd_ready = 1'b0;
        do_start({$urandom(), $urandom()}, dec);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (round == 4'd7 && cd_valid && stall7 < 10) begin
                cd_ready = 1'b0;
                stall7++;
            end else begin
                cd_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (held) begin
                checks++;
                if (!cd_valid || cd_out !== held_cd || round !== held_rnd) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b cd_out=%h round=%0d, expected 1 %h %0d",
                             cd_valid, cd_out, round, held_cd, held_rnd);
                end
            end
            held     = cd_valid && !cd_ready;
            held_cd  = cd_out;
            held_rnd = round;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (!got || exp_cd_q.size() != 0 || stall7 != 10) begin
            errors++;
            $display("FAIL stall_complete: got done=%b leftover=%0d stall7=%0d, expected 1/0/10",
                     got, exp_cd_q.size(), stall7);
        end
        exp_cd_q.delete();
        exp_rnd_q.delete();
    endtask

    task automatic test_start_during_run();
        bit got;
        logic [55:0] b0, b15;
        cd_ready = 1'b1;
        do_start({$urandom(), $urandom()}, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b1; key_in = {$urandom(), $urandom()}; decrypt = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL run_ready: got ready=%b during RUN, expected 0", ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        drive_until_done(got, b0, b15);
        @(negedge clk);
        checks++;
        if (!got || exp_cd_q.size() != 0 || cd_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_ignore: got done=%b leftover=%0d valid=%b, expected 1/0/0",
                     got, exp_cd_q.size(), cd_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit got, found;
        logic [55:0] b0, b15;
        found = 1'b0;
        cd_ready = 1'b1;
        do_start({$urandom(), $urandom()}, 1'b1);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got done=%b ready=%b, expected 1/1", found, ready);
        end
        key_in = {$urandom(), $urandom()}; decrypt = 1'b0; start = 1'b1;
        push_expected(key_in, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({cd_valid, done, round} !== {2'b10, 4'd0}) begin
            errors++;
            $display("FAIL b2b_beat0: got valid/done=%b%b round=%0d, expected 10 round=0", cd_valid, done, round);
        end
        @(posedge clk); #1;
        drive_until_done(got, b0, b15);
        checks++;
        if (!got || exp_cd_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete: got done=%b leftover=%0d, expected 1/0", got, exp_cd_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit got, found;
        logic [55:0] b0, b15;
        found = 1'b0;
        cd_ready = 1'b1;
        do_start({$urandom(), $urandom()}, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (round == 4'd5 && cd_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (!found || {cd_valid, ready, done} !== 3'b010 || round !== 4'd0 || cd_out !== 56'd0) begin
            errors++;
            $display("FAIL midrst_state: got valid/ready/done=%b%b%b round=%0d cd_out=%h, expected 010/0/0",
                     cd_valid, ready, done, round, cd_out);
        end
        rst_n = 1'b1;
        exp_cd_q.delete();
        exp_rnd_q.delete();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone: got done=%b valid=%b, expected 0/0", done, cd_valid);
        end
        @(posedge clk); #1;
        do_start(FIPS_KEY, 1'b0);
        drive_until_done(got, b0, b15);
        checks++;
        if (!got || exp_cd_q.size() != 0 || pc2(b0) !== 48'h1B02EFFC7072) begin
            errors++;
            $display("FAIL midrst_restart: got done=%b leftover=%0d K1=%h, expected 1/0/1b02effc7072",
                     got, exp_cd_q.size(), pc2(b0));
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_stalls(1'b0);
        test_stalls(1'b1);
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
